// File: rtl/nangate45_8x64_1p_bit_bist.sv
// March C- BIST controller for the 8x64 single-port bit-masked SRAM.
// Drives every macro cycle and reports the first failing address/data.
module nangate45_8x64_1p_bit_bist #(
  parameter int BITS       = 8,
  parameter int WORD_DEPTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  fail_out,
  output logic [ADDR_WIDTH-1:0] fail_addr_out,
  output logic [BITS-1:0]       fail_data_out,
  output logic                  sram_ce_out,
  output logic                  sram_we_out,
  output logic [ADDR_WIDTH-1:0] sram_addr_out,
  output logic [BITS-1:0]       sram_wd_out,
  output logic [BITS-1:0]       sram_w_mask_out,
  input  logic [BITS-1:0]       sram_rd_in
);

  typedef enum logic [3:0] {
    IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(WORD_DEPTH - 1);

  state_t                  state, state_nx, succ;
  logic [ADDR_WIDTH-1:0]   addr, addr_nx, end_addr;
  logic                    phase, phase_nx;
  logic                    march, asc, start_go;
  logic                    rd_op, wr_op, rd_pat, wr_pat;
  logic                    cmp_vld;
  logic [BITS-1:0]         cmp_exp;
  logic [ADDR_WIDTH-1:0]   cmp_addr;

  // Per-element op decode; phase 0 is the read, phase 1 the write.
  always_comb begin
    march  = 1'b0;
    rd_op  = 1'b0;
    wr_op  = 1'b0;
    rd_pat = 1'b0;
    wr_pat = 1'b0;
    asc    = 1'b1;
    succ   = state;
    unique case (state)
      M0: begin
        march = 1'b1;
        wr_op = 1'b1;
        succ  = M1;
      end
      M1: begin
        march  = 1'b1;
        rd_op  = !phase;
        wr_op  = phase;
        wr_pat = 1'b1;
        succ   = M2;
      end
      M2: begin
        march  = 1'b1;
        rd_op  = !phase;
        wr_op  = phase;
        rd_pat = 1'b1;
        succ   = M3;
      end
      M3: begin
        march  = 1'b1;
        rd_op  = !phase;
        wr_op  = phase;
        wr_pat = 1'b1;
        asc    = 1'b0;
        succ   = M4;
      end
      M4: begin
        march  = 1'b1;
        rd_op  = !phase;
        wr_op  = phase;
        rd_pat = 1'b1;
        asc    = 1'b0;
        succ   = M5;
      end
      M5: begin
        march = 1'b1;
        rd_op = 1'b1;
        succ  = DRAIN;
      end
      default: ;
    endcase
  end

  assign end_addr = asc ? LAST : '0;
  assign start_go = start_in &&
                    (state == IDLE || state == DONE);

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    phase_nx = phase;
    unique case (state)
      IDLE, DONE: begin
        if (start_in) begin
          state_nx = M0;
          addr_nx  = '0;
          phase_nx = 1'b0;
        end
      end
      DRAIN: state_nx = DONE;
      default: begin
        if (rd_op && state != M5) begin
          phase_nx = 1'b1;
        end else begin
          phase_nx = 1'b0;
          if (addr == end_addr) begin
            state_nx = succ;
            addr_nx  = (succ == M3 || succ == M4)
                       ? LAST : '0;
          end else if (asc) begin
            addr_nx = addr + ADDR_WIDTH'(1);
          end else begin
            addr_nx = addr - ADDR_WIDTH'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr  <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      phase <= phase_nx;
    end
  end

  // Read data returns one cycle after the read op; X counts as a miss.
  always_ff @(posedge clk) begin
    if (reset || start_go) begin
      cmp_vld       <= 1'b0;
      cmp_exp       <= '0;
      cmp_addr      <= '0;
      fail_out      <= 1'b0;
      fail_addr_out <= '0;
      fail_data_out <= '0;
    end else begin
      cmp_vld  <= rd_op;
      cmp_exp  <= rd_pat ? '1 : '0;
      cmp_addr <= addr;
      if (cmp_vld && (sram_rd_in !== cmp_exp)) begin
        fail_out <= 1'b1;
        if (!fail_out) begin
          fail_addr_out <= cmp_addr;
          fail_data_out <= sram_rd_in;
        end
      end
    end
  end

  assign busy_out        = march || (state == DRAIN);
  assign done_out        = (state == DONE);
  assign sram_ce_out     = march;
  assign sram_we_out     = wr_op;
  assign sram_addr_out   = march ? addr : '0;
  assign sram_wd_out     = (wr_op && wr_pat) ? '1 : '0;
  assign sram_w_mask_out = '1;

endmodule

// File: tb/tb_nangate45_8x64_1p_bit_bist.sv
// Bench for the March C- BIST controller with a behavioural
// 8x64 macro model that can inject a stuck-at-1 bit.
module tb_nangate45_8x64_1p_bit_bist;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_in = 1'b0;
  logic       busy_out, done_out, fail_out;
  logic [5:0] fail_addr_out;
  logic [7:0] fail_data_out;
  logic       sram_ce_out, sram_we_out;
  logic [5:0] sram_addr_out;
  logic [7:0] sram_wd_out, sram_w_mask_out;
  logic [7:0] sram_rd_in = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  logic       fault_en = 1'b0;
  logic [7:0] mem [64];

  typedef struct {
    int         lat;
    int         first_fail;
    logic       fail;
    logic [5:0] fa;
    logic [7:0] fd;
  } run_exp_t;

  typedef struct {
    logic [5:0] a;
    logic       we;
    logic [7:0] wd;
  } op_exp_t;

  run_exp_t run_q[$];
  op_exp_t  op_q[$];

  always #5 clk = ~clk;

  nangate45_8x64_1p_bit_bist dut (
    .clk             (clk),
    .reset           (reset),
    .start_in        (start_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .fail_out        (fail_out),
    .fail_addr_out   (fail_addr_out),
    .fail_data_out   (fail_data_out),
    .sram_ce_out     (sram_ce_out),
    .sram_we_out     (sram_we_out),
    .sram_addr_out   (sram_addr_out),
    .sram_wd_out     (sram_wd_out),
    .sram_w_mask_out (sram_w_mask_out),
    .sram_rd_in      (sram_rd_in)
  );

  always @(posedge clk) begin
    if (sram_ce_out) begin
      if (sram_we_out)
        mem[sram_addr_out] <=
          (mem[sram_addr_out] & ~sram_w_mask_out) |
          (sram_wd_out & sram_w_mask_out);
      else
        sram_rd_in <= mem[sram_addr_out] |
          ((fault_en && sram_addr_out == 6'd5)
           ? 8'h08 : 8'h00);
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start_in = 1'b1;
    @(posedge clk);
    #1 start_in = 1'b0;
  endtask

  task automatic wait_done(input int poke_at,
                           output int lat,
                           output int first_fail);
    lat = -1;
    first_fail = -1;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk);
      #1;
      start_in = (n == poke_at);
      if (fail_out && first_fail < 0) first_fail = n;
      if (done_out) begin
        lat = n;
        break;
      end
    end
    start_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy_out, done_out, fail_out} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags got %b want 000",
               {busy_out, done_out, fail_out});
    end
    n_cmp++;
    if ({fail_addr_out, fail_data_out} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_fail_regs got %h/%h want 0/0",
               fail_addr_out, fail_data_out);
    end
    n_cmp++;
    if ({sram_ce_out, sram_we_out, sram_addr_out,
         sram_wd_out} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_port got ce%b we%b a%h d%h want 0",
               sram_ce_out, sram_we_out, sram_addr_out,
               sram_wd_out);
    end
    n_cmp++;
    if (sram_w_mask_out !== 8'hFF) begin
      n_err++;
      $display("FAIL reset_mask got %h want ff",
               sram_w_mask_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_fault_free();
    int lat, ff;
    run_exp_t e;
    fault_en = 1'b0;
    run_q.push_back('{641, -1, 1'b0, 6'd0, 8'h00});
    pulse_start();
    wait_done(0, lat, ff);
    e = run_q.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_err++;
      $display("FAIL ff_latency got %0d want %0d", lat, e.lat);
    end
    n_cmp++;
    if ({fail_out, fail_addr_out} !== {e.fail, e.fa}) begin
      n_err++;
      $display("FAIL ff_verdict got %b/%0d want %b/%0d",
               fail_out, fail_addr_out, e.fail, e.fa);
    end
    n_cmp++;
    if (ff !== e.first_fail) begin
      n_err++;
      $display("FAIL ff_no_fail got %0d want %0d",
               ff, e.first_fail);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({done_out, busy_out} !== 2'b10) begin
      n_err++;
      $display("FAIL done_hold got %b want 10",
               {done_out, busy_out});
    end
  endtask

  task automatic test_stuck_fault();
    int lat, ff;
    run_exp_t e;
    fault_en = 1'b1;
    run_q.push_back('{641, 76, 1'b1, 6'd5, 8'h08});
    pulse_start();
    wait_done(0, lat, ff);
    e = run_q.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_err++;
      $display("FAIL sf_latency got %0d want %0d", lat, e.lat);
    end
    n_cmp++;
    if (ff !== e.first_fail) begin
      n_err++;
      $display("FAIL sf_fail_edge got %0d want %0d",
               ff, e.first_fail);
    end
    n_cmp++;
    if ({fail_out, fail_addr_out, fail_data_out} !==
        {e.fail, e.fa, e.fd}) begin
      n_err++;
      $display("FAIL sf_capture got %b/%0d/%h want %b/%0d/%h",
               fail_out, fail_addr_out, fail_data_out,
               e.fail, e.fa, e.fd);
    end
  endtask

  task automatic test_restart_clean();
    int lat, ff;
    run_exp_t e;
    fault_en = 1'b0;
    run_q.push_back('{641, -1, 1'b0, 6'd0, 8'h00});
    pulse_start();
    n_cmp++;
    if ({fail_out, done_out} !== 2'b00) begin
      n_err++;
      $display("FAIL rs_clear got %b want 00",
               {fail_out, done_out});
    end
    wait_done(0, lat, ff);
    e = run_q.pop_front();
    n_cmp++;
    if ({lat, ff} !== {e.lat, e.first_fail}) begin
      n_err++;
      $display("FAIL rs_run got lat%0d ff%0d want %0d %0d",
               lat, ff, e.lat, e.first_fail);
    end
  endtask

  task automatic test_m3_order();
    int lat, ff;
    op_exp_t o;
    for (int a = 63; a >= 0; a--) begin
      op_q.push_back('{6'(a), 1'b0, 8'h00});
      op_q.push_back('{6'(a), 1'b1, 8'hFF});
    end
    pulse_start();
    for (int k = 1; k <= 448; k++) begin
      @(negedge clk);
      if (k >= 321) begin
        o = op_q.pop_front();
        n_cmp++;
        if ({sram_ce_out, sram_addr_out, sram_we_out,
             sram_wd_out} !== {1'b1, o.a, o.we, o.wd}) begin
          n_err++;
          $display("FAIL m3_op%0d got a%0d we%b d%h want a%0d we%b d%h",
                   k, sram_addr_out, sram_we_out, sram_wd_out,
                   o.a, o.we, o.wd);
        end
      end
    end
    wait_done(0, lat, ff);
    n_cmp++;
    if (lat < 0 || 447 + lat !== 641) begin
      n_err++;
      $display("FAIL m3_latency got %0d want 641",
               (lat < 0) ? -1 : 447 + lat);
    end
  endtask

  task automatic test_ignore_start();
    int lat, ff;
    run_exp_t e;
    fault_en = 1'b0;
    run_q.push_back('{641, -1, 1'b0, 6'd0, 8'h00});
    pulse_start();
    wait_done(99, lat, ff);
    e = run_q.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_err++;
      $display("FAIL ign_latency got %0d want %0d", lat, e.lat);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, ff;
    run_exp_t e;
    fault_en = 1'b1;
    pulse_start();
    repeat (299) @(posedge clk);
    #1;
    n_cmp++;
    if ({fail_out, busy_out} !== 2'b11) begin
      n_err++;
      $display("FAIL mr_pre got %b want 11",
               {fail_out, busy_out});
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({sram_ce_out, busy_out, done_out, fail_out}
        !== 4'b0000) begin
      n_err++;
      $display("FAIL mr_reset got %b want 0000",
               {sram_ce_out, busy_out, done_out, fail_out});
    end
    reset = 1'b0;
    fault_en = 1'b0;
    run_q.push_back('{641, -1, 1'b0, 6'd0, 8'h00});
    pulse_start();
    wait_done(0, lat, ff);
    e = run_q.pop_front();
    n_cmp++;
    if ({lat, ff} !== {e.lat, e.first_fail}) begin
      n_err++;
      $display("FAIL mr_restart got lat%0d ff%0d want %0d %0d",
               lat, ff, e.lat, e.first_fail);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    test_reset();
    test_fault_free();
    test_stuck_fault();
    test_restart_clean();
    test_m3_order();
    test_ignore_start();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
